uart_apb_master: RTL



---
 rtl/uart_apb_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_apb_master.sv
// uart_apb_master: APB requester for the UART slave: divisor writes, TX writes with PSLVERR
// retry/backoff, and periodic RX polling when the UART_APB_RX_POLL_EN macro is defined.
module uart_apb_master #(
    parameter int APB_DW    = 8,
    parameter int POLL_W    = 8,
    parameter int POLL_CYC  = 32,
    parameter int RETRY_MAX = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [APB_DW-1:0] cfg_div,
    output logic              cfg_ready,
    input  logic              tx_valid,
    input  logic [APB_DW-1:0] tx_byte,
    output logic              tx_ready,
    output logic              tx_drop,
    output logic              rx_valid,
    output logic [APB_DW-1:0] rx_byte,
    input  logic              rx_ready,
    output logic              apb_timeout,
    output logic [APB_DW-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PSLVERR
);
    // Handshakes: cfg_valid/tx_valid are held with stable data until the matching one-cycle
    // ready pulse; rx_byte is held while rx_valid and taken on a cycle with rx_valid && rx_ready.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [APB_DW-1:0] A_RX  = APB_DW'(0);
    localparam logic [APB_DW-1:0] A_DIV = APB_DW'(1);
    localparam logic [APB_DW-1:0] A_TX  = APB_DW'(2);

    localparam int RW = $clog2(RETRY_MAX + 2);

    logic [1:0]        state;
    logic [7:0]        tcnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [RW-1:0]     retry_cnt;
    logic              tx_hold;
    logic              poll_due;
    logic              tx_ok;
    logic              done;
    logic              ok_resp;
    logic              rx_take;

    assign PSEL    = (state != S_IDLE);
    assign PENABLE = (state == S_ACCESS);

    // ACCESS ends on PREADY or after TIMEOUT cycles without it.
    assign done    = (state == S_ACCESS) && (PREADY || (tcnt == 8'(TIMEOUT - 1)));
    assign ok_resp = PREADY && !PSLVERR;
    assign rx_take = done && ok_resp && (PADDR == A_RX);

    // After a rejected TX write the shared interval counter doubles as the retry backoff.
    assign tx_ok = tx_valid && (!tx_hold || (poll_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            poll_cnt    <= POLL_W'(POLL_CYC);
            retry_cnt   <= '0;
            tx_hold     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            cfg_ready   <= 1'b0;
            tx_ready    <= 1'b0;
            tx_drop     <= 1'b0;
            apb_timeout <= 1'b0;
        end else begin
            cfg_ready   <= 1'b0;
            tx_ready    <= 1'b0;
            tx_drop     <= 1'b0;
            apb_timeout <= 1'b0;
            if (poll_cnt != '0) begin
                poll_cnt <= poll_cnt - 1'b1;
            end
            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    if (cfg_valid) begin
                        PADDR  <= A_DIV;
                        PWRITE <= 1'b1;
                        PWDATA <= cfg_div;
                        state  <= S_SETUP;
                    end else if (tx_ok) begin
                        PADDR   <= A_TX;
                        PWRITE  <= 1'b1;
                        PWDATA  <= tx_byte;
                        tx_hold <= 1'b0;
                        state   <= S_SETUP;
                    end else if (poll_due) begin
                        PADDR  <= A_RX;
                        PWRITE <= 1'b0;
                        PWDATA <= '0;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: begin
                    if (done) begin
                        state       <= S_IDLE;
                        apb_timeout <= !PREADY;
                        if (PADDR == A_DIV) begin
                            // A timed-out divisor write stays pending and is simply reissued.
                            cfg_ready <= PREADY;
                        end else if (PADDR == A_TX) begin
                            if (ok_resp) begin
                                tx_ready  <= 1'b1;
                                retry_cnt <= '0;
                            end else if (retry_cnt == RW'(RETRY_MAX)) begin
                                tx_ready  <= 1'b1;
                                tx_drop   <= 1'b1;
                                retry_cnt <= '0;
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                                tx_hold   <= 1'b1;
                                poll_cnt  <= POLL_W'(POLL_CYC);
                            end
                        end else begin
                            poll_cnt <= POLL_W'(POLL_CYC);
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_APB_RX_POLL_EN
    assign poll_due = (poll_cnt == '0) && !rx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else if (rx_take) begin
            rx_valid <= 1'b1;
            rx_byte  <= PRDATA;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
`else
    assign poll_due = 1'b0;
    assign rx_valid = 1'b0;
    assign rx_byte  = '0;

    logic unused_rx;
    assign unused_rx = ^{rx_ready, PRDATA, rx_take};
`endif

endmodule
